// File: rtl/reg_write_queue_if.sv
// Bundle of write-request, register-file drain and read-hazard signals for reg_write_queue.
// Forwarding outputs ra_fwd/rb_fwd exist only when BYPASS_EN is defined.
interface reg_write_queue_if #(
    parameter int N     = 2,
    parameter int W     = 16,
    parameter int DEPTH = 4
);
    localparam int M  = 2 ** N;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  w_adr;
    logic [W-1:0]  w_data;
    logic          stall;
    logic [M-1:0]  we;
    logic [W-1:0]  wd;
    logic [N-1:0]  ra_adr;
    logic [N-1:0]  rb_adr;
    logic          ra_ena;
    logic          rb_ena;
    logic          ra_pend;
    logic          rb_pend;
    logic [CW-1:0] count;
`ifdef BYPASS_EN
    logic [W-1:0]  ra_fwd;
    logic [W-1:0]  rb_fwd;
`endif

    modport master (
        output in_valid, w_adr, w_data, stall, ra_adr, rb_adr, ra_ena, rb_ena,
`ifdef BYPASS_EN
        input  ra_fwd, rb_fwd,
`endif
        input  in_ready, we, wd, ra_pend, rb_pend, count
    );

    modport slave (
        input  in_valid, w_adr, w_data, stall, ra_adr, rb_adr, ra_ena, rb_ena,
`ifdef BYPASS_EN
        output ra_fwd, rb_fwd,
`endif
        output in_ready, we, wd, ra_pend, rb_pend, count
    );
endinterface

// File: rtl/reg_write_queue.sv
// Register-file write queue: FIFO-buffered writes drained as a registered one-hot We plus Wd,
// with read-after-write hazard flags. Optional feature macro: BYPASS_EN (youngest-write forwarding).
module reg_write_queue #(
    parameter int N     = 2,
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    reg_write_queue_if.slave bus
);
    localparam int M  = 2 ** N;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]   adr_mem [DEPTH];
    logic [W-1:0]   data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]  head_reg;
    logic [AW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic [M-1:0]   we_reg;
    logic [W-1:0]   wd_reg;
    logic           ready;
    logic           push;
    logic           pop;
    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;

    // No pass-through when full: a pop in the same cycle does not free a slot for a push.
    assign ready = (count_reg != CW'(DEPTH)) && !reset;
    assign push  = bus.in_valid && ready;
    assign pop   = (count_reg != '0) && !bus.stall;

    assign bus.in_ready = ready;
    assign bus.we       = we_reg;
    assign bus.wd       = wd_reg;
    assign bus.count    = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[tail_reg]  <= bus.w_adr;
            data_mem[tail_reg] <= bus.w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            we_reg    <= '0;
            wd_reg    <= '0;
        end else begin
            // push and pop never address the same slot: that needs empty (no pop) or full (no push)
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + 1'b1;
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + 1'b1;
                we_reg              <= M'(1) << adr_mem[head_reg];
                wd_reg              <= data_mem[head_reg];
            end else begin
                we_reg <= '0;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_a[gi] = valid_reg[gi] && (adr_mem[gi] == bus.ra_adr);
            assign hit_b[gi] = valid_reg[gi] && (adr_mem[gi] == bus.rb_adr);
        end
    endgenerate

    assign bus.ra_pend = bus.ra_ena && ((|hit_a) || we_reg[bus.ra_adr]);
    assign bus.rb_pend = bus.rb_ena && ((|hit_b) || we_reg[bus.rb_adr]);

`ifdef BYPASS_EN
    logic [W-1:0] fwd_a;
    logic [W-1:0] fwd_b;

    // Walk oldest to newest so the youngest matching entry wins; output stage is older than all.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (we_reg[bus.ra_adr]) fwd_a = wd_reg;
        if (we_reg[bus.rb_adr]) fwd_b = wd_reg;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit_a[head_reg + AW'(k)]) fwd_a = data_mem[head_reg + AW'(k)];
            if (hit_b[head_reg + AW'(k)]) fwd_b = data_mem[head_reg + AW'(k)];
        end
        if (!bus.ra_pend) fwd_a = '0;
        if (!bus.rb_pend) fwd_b = '0;
    end

    assign bus.ra_fwd = fwd_a;
    assign bus.rb_fwd = fwd_b;
`endif
endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_reg_write_queue;
    localparam int N     = 2;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int M     = 2 ** N;

    typedef struct packed {
        logic [N-1:0] adr;
        logic [W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_write_queue_if #(.N(N), .W(W), .DEPTH(DEPTH)) bus ();

    reg_write_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t         q[$];
    logic         out_valid;
    logic [N-1:0] out_adr;
    logic [W-1:0] out_wd;
    int           compared   = 0;
    int           mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pend(input logic ena, input logic [N-1:0] a);
        logic h;
        h = 1'b0;
        foreach (q[i]) if (q[i].adr == a) h = 1'b1;
        if (out_valid && out_adr == a) h = 1'b1;
        return ena && h;
    endfunction

    function automatic logic [W-1:0] exp_fwd(input logic ena, input logic [N-1:0] a);
        if (!exp_pend(ena, a)) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].adr == a) return q[i].data;
        return out_wd;
    endfunction

    task automatic check_comb();
        chk("in_ready", 64'(bus.in_ready), 64'((q.size() != DEPTH) && !reset));
        chk("ra_pend", 64'(bus.ra_pend), 64'(exp_pend(bus.ra_ena, bus.ra_adr)));
        chk("rb_pend", 64'(bus.rb_pend), 64'(exp_pend(bus.rb_ena, bus.rb_adr)));
`ifdef BYPASS_EN
        chk("ra_fwd", 64'(bus.ra_fwd), 64'(exp_fwd(bus.ra_ena, bus.ra_adr)));
        chk("rb_fwd", 64'(bus.rb_fwd), 64'(exp_fwd(bus.rb_ena, bus.rb_adr)));
`endif
    endtask

    task automatic check_reg();
        logic [M-1:0] exp_we;
        exp_we = out_valid ? (M'(1) << out_adr) : '0;
        chk("we", 64'(bus.we), 64'(exp_we));
        chk("wd", 64'(bus.wd), 64'(out_wd));
        chk("count", 64'(bus.count), 64'(q.size()));
    endtask

    // One clock: inputs are already set; check combinational outputs, clock, update model, check registers.
    task automatic cyc();
        logic do_push;
        logic do_pop;
        ent_t e;
        ent_t nw;
        #1;
        check_comb();
        do_push = bus.in_valid && (q.size() != DEPTH) && !reset;
        do_pop  = (q.size() != 0) && !bus.stall;
        nw      = '{adr: bus.w_adr, data: bus.w_data};
        @(posedge clk);
        if (reset) begin
            q.delete();
            out_valid = 1'b0;
            out_wd    = '0;
        end else begin
            if (do_pop) begin
                e         = q.pop_front();
                out_valid = 1'b1;
                out_adr   = e.adr;
                out_wd    = e.data;
            end else begin
                out_valid = 1'b0;
            end
            if (do_push) q.push_back(nw);
        end
        #1;
        check_reg();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [N-1:0] a, input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.w_adr    = a;
        bus.w_data   = d;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.w_adr    = '0;
        bus.w_data   = '0;
        bus.stall    = 1'b0;
        bus.ra_adr   = '0;
        bus.rb_adr   = '0;
        bus.ra_ena   = 1'b0;
        bus.rb_ena   = 1'b0;
        out_valid    = 1'b0;
        out_adr      = '0;
        out_wd       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // 1: reset held, then released
        cyc();
        reset = 1'b0;
        cyc();
        chk("t1_count", 64'(bus.count), 64'd0);
        chk("t1_ready", 64'(bus.in_ready), 64'd1);

        // 2: single write, latency and one-cycle pulse
        push_one(2'd2, 16'hA5A5);
        chk("t2_we_early", 64'(bus.we), 64'd0);
        cyc();
        chk("t2_we", 64'(bus.we), 64'b0100);
        chk("t2_wd", 64'(bus.wd), 64'hA5A5);
        cyc();
        chk("t2_we_off", 64'(bus.we), 64'd0);
        chk("t2_count", 64'(bus.count), 64'd0);

        // 3: fill while stalled, 5th held, then drain
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) push_one(N'(i), 16'h1000 + 16'(i));
        chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.w_adr    = 2'd1;
        bus.w_data   = 16'h1004;
        cyc();
        chk("t3_count_full", 64'(bus.count), 64'd4);
        bus.stall = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = (q.size() != DEPTH);
            cyc();
        end
        chk("t3_fifth_accepted", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        repeat (7) cyc();
        chk("t3_count_end", 64'(bus.count), 64'd0);

        // 4: hazard flags
        bus.stall = 1'b1;
        push_one(2'd1, 16'h0001);
        push_one(2'd3, 16'h0003);
        bus.ra_ena = 1'b1; bus.ra_adr = 2'd3;
        bus.rb_ena = 1'b0; bus.rb_adr = 2'd1;
        #1;
        chk("t4_ra_pend", 64'(bus.ra_pend), 64'd1);
        chk("t4_rb_pend", 64'(bus.rb_pend), 64'd0);
        bus.stall = 1'b0;
        repeat (3) cyc();
        chk("t4_ra_clear", 64'(bus.ra_pend), 64'd0);

        // 5: reset mid-drain discards everything
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) push_one(N'(i + 1), 16'h5000 + 16'(i));
        bus.stall = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.ra_ena = 1'b1; bus.rb_ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ra_adr = N'(i + 1);
            bus.rb_adr = N'(i);
            cyc();
            chk("t5_we", 64'(bus.we), 64'd0);
            chk("t5_count", 64'(bus.count), 64'd0);
            chk("t5_pend", 64'({bus.ra_pend, bus.rb_pend}), 64'd0);
        end

`ifdef BYPASS_EN
        // 6: forwarding picks the youngest write
        bus.stall = 1'b1;
        push_one(2'd0, 16'h0011);
        push_one(2'd0, 16'h0022);
        bus.ra_adr = 2'd0; bus.ra_ena = 1'b1;
        #1;
        chk("t6_fwd", 64'(bus.ra_fwd), 64'h0022);
        bus.stall = 1'b0;
        repeat (4) cyc();
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.w_adr    = N'($urandom);
            bus.w_data   = W'($urandom);
            bus.stall    = ($urandom_range(0, 9) < 3);
            bus.ra_adr   = N'($urandom);
            bus.rb_adr   = N'($urandom);
            bus.ra_ena   = 1'($urandom);
            bus.rb_ena   = 1'($urandom);
            reset        = ($urandom_range(0, 49) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
